// File: rtl/bist_fault_pkg.sv
// Package: bist_fault_pkg
// Purpose: shared fault codes and field-width helpers for the fault-injecting
//          BIST responder memory (bist_fault_memory) and its fault table.
// Contents:
//   FLT_*          3-bit fault codes stored in each fault-table entry
//   FLT_TYPE_W     width of a fault code
//   idx_width()    width of an index field that must be at least one bit wide
//   fault_active() true for codes that describe a real fault (1..5)
package bist_fault_pkg;

    localparam int FLT_TYPE_W = 3;

    localparam logic [FLT_TYPE_W-1:0] FLT_NONE    = 3'd0;
    localparam logic [FLT_TYPE_W-1:0] FLT_SA0     = 3'd1;  // victim bit stuck at 0
    localparam logic [FLT_TYPE_W-1:0] FLT_SA1     = 3'd2;  // victim bit stuck at 1
    localparam logic [FLT_TYPE_W-1:0] FLT_TF_UP   = 3'd3;  // victim bit cannot rise 0->1
    localparam logic [FLT_TYPE_W-1:0] FLT_TF_DOWN = 3'd4;  // victim bit cannot fall 1->0
    localparam logic [FLT_TYPE_W-1:0] FLT_CF_INV  = 3'd5;  // aggressor write inverts victim bit

    // $clog2(1) is 0; index ports still need one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Codes 6 and 7 are reserved and behave as NONE.
    function automatic logic fault_active(input logic [FLT_TYPE_W-1:0] code);
        return (code >= FLT_SA0) && (code <= FLT_CF_INV);
    endfunction

endpackage

// File: rtl/bist_fault_table.sv
// Module: bist_fault_table
// Purpose: register file of NUM_FAULTS injected-fault entries with a simple
//          config write port. Entries are exported as flat vectors so the
//          memory can scan all of them combinationally.
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears all entries)
//   cfg_we              write entry cfg_idx with cfg_type/addr/bit/aggr
//   cfg_clear           invalidate every entry; wins over cfg_we
//   cfg_idx             entry index (indices >= NUM_FAULTS are ignored)
//   cfg_type            fault code (bist_fault_pkg::FLT_*)
//   cfg_addr, cfg_bit   victim cell
//   cfg_aggr            aggressor address (coupling faults only)
//   f_valid             per-entry valid (only set for an active fault code)
//   f_type/addr/bit/aggr  entry i occupies slice [i*W +: W]
module bist_fault_table
    import bist_fault_pkg::*;
#(
    parameter int NUM_FAULTS = 4,
    parameter int AW         = 5,
    parameter int BW         = 5,
    parameter int IW         = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             cfg_we,
    input  logic                             cfg_clear,
    input  logic [IW-1:0]                    cfg_idx,
    input  logic [FLT_TYPE_W-1:0]            cfg_type,
    input  logic [AW-1:0]                    cfg_addr,
    input  logic [BW-1:0]                    cfg_bit,
    input  logic [AW-1:0]                    cfg_aggr,
    output logic [NUM_FAULTS-1:0]            f_valid,
    output logic [NUM_FAULTS*FLT_TYPE_W-1:0] f_type,
    output logic [NUM_FAULTS*AW-1:0]         f_addr,
    output logic [NUM_FAULTS*BW-1:0]         f_bit,
    output logic [NUM_FAULTS*AW-1:0]         f_aggr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_valid <= '0;
            f_type  <= '0;
            f_addr  <= '0;
            f_bit   <= '0;
            f_aggr  <= '0;
        end else if (cfg_clear) begin
            f_valid <= '0;
            f_type  <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_FAULTS; i++) begin
                if (i == int'(cfg_idx)) begin
                    f_valid[i]                          <= fault_active(cfg_type);
                    f_type[i*FLT_TYPE_W +: FLT_TYPE_W]  <= cfg_type;
                    f_addr[i*AW +: AW]                  <= cfg_addr;
                    f_bit[i*BW +: BW]                   <= cfg_bit;
                    f_aggr[i*AW +: AW]                  <= cfg_aggr;
                end
            end
        end
    end

endmodule

// File: rtl/bist_fault_memory.sv
// Module: bist_fault_memory
// Purpose: single-port register-array memory answering the BIST controller's
//          memory interface, with a programmable table of injected cell faults
//          (stuck-at, transition, inversion coupling) applied on writes and reads.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mem_enable, mem_write     access request; write when mem_write=1, else read
//   mem_addr, mem_wdata       word address, write data
//   mem_rdata, rd_valid       registered read data and its one-cycle strobe
//   cfg_*                     fault-table programming port (see bist_fault_table)
//   wr_count, rd_count        saturating counts of accepted writes / reads
//
// Handshake: there is no back-pressure. Every cycle with mem_enable=1 is an
// accepted access. A read accepted at edge N drives mem_rdata and pulses
// rd_valid for exactly the cycle after edge N; mem_rdata then holds its value
// until the next read. Back-to-back accesses see each other's results.
module bist_fault_memory
    import bist_fault_pkg::*;
#(
    parameter  int MEM_ADDR_WIDTH = 5,
    parameter  int MEM_DATA_WIDTH = 32,
    parameter  int NUM_FAULTS     = 4,
    localparam int IDX_W          = idx_width(NUM_FAULTS),
    localparam int BIT_W          = idx_width(MEM_DATA_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_enable,
    input  logic                      mem_write,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    input  logic [MEM_DATA_WIDTH-1:0] mem_wdata,
    output logic [MEM_DATA_WIDTH-1:0] mem_rdata,
    output logic                      rd_valid,
    input  logic                      cfg_we,
    input  logic                      cfg_clear,
    input  logic [IDX_W-1:0]          cfg_idx,
    input  logic [FLT_TYPE_W-1:0]     cfg_type,
    input  logic [MEM_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [BIT_W-1:0]          cfg_bit,
    input  logic [MEM_ADDR_WIDTH-1:0] cfg_aggr,
    output logic [31:0]               wr_count,
    output logic [31:0]               rd_count
);

    localparam int AW    = MEM_ADDR_WIDTH;
    localparam int DW    = MEM_DATA_WIDTH;
    localparam int DEPTH = 1 << AW;

    // ---------------- fault table ----------------
    logic [NUM_FAULTS-1:0]            f_valid;
    logic [NUM_FAULTS*FLT_TYPE_W-1:0] f_type_flat;
    logic [NUM_FAULTS*AW-1:0]         f_addr_flat;
    logic [NUM_FAULTS*BIT_W-1:0]      f_bit_flat;
    logic [NUM_FAULTS*AW-1:0]         f_aggr_flat;

    bist_fault_table #(
        .NUM_FAULTS (NUM_FAULTS),
        .AW         (AW),
        .BW         (BIT_W),
        .IW         (IDX_W)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_clear (cfg_clear),
        .cfg_idx   (cfg_idx),
        .cfg_type  (cfg_type),
        .cfg_addr  (cfg_addr),
        .cfg_bit   (cfg_bit),
        .cfg_aggr  (cfg_aggr),
        .f_valid   (f_valid),
        .f_type    (f_type_flat),
        .f_addr    (f_addr_flat),
        .f_bit     (f_bit_flat),
        .f_aggr    (f_aggr_flat)
    );

    logic [FLT_TYPE_W-1:0] ft [NUM_FAULTS];
    logic [AW-1:0]         fa [NUM_FAULTS];
    logic [BIT_W-1:0]      fb [NUM_FAULTS];
    logic [AW-1:0]         fg [NUM_FAULTS];

    always_comb begin
        for (int i = 0; i < NUM_FAULTS; i++) begin
            ft[i] = f_type_flat[i*FLT_TYPE_W +: FLT_TYPE_W];
            fa[i] = f_addr_flat[i*AW +: AW];
            fb[i] = f_bit_flat[i*BIT_W +: BIT_W];
            fg[i] = f_aggr_flat[i*AW +: AW];
        end
    end

    // ---------------- array and fault masking ----------------
    logic [DW-1:0] mem      [DEPTH];
    logic [DW-1:0] mem_next [DEPTH];
    logic [DW-1:0] old_word;
    logic [DW-1:0] wr_word;
    logic [DW-1:0] rd_word;
    logic          wr_fire;
    logic          rd_fire;

    assign wr_fire = mem_enable &  mem_write;
    assign rd_fire = mem_enable & ~mem_write;

    // Write data as the faulty cell would store it. Entries are applied in
    // ascending order, so the highest matching index has the final say.
    // Transition faults compare against the bit currently stored in the cell.
    always_comb begin
        old_word = mem[mem_addr];
        wr_word  = mem_wdata;
        for (int i = 0; i < NUM_FAULTS; i++) begin
            if (f_valid[i] && fa[i] == mem_addr) begin
                case (ft[i])
                    FLT_SA0:     wr_word[fb[i]] = 1'b0;
                    FLT_SA1:     wr_word[fb[i]] = 1'b1;
                    FLT_TF_UP:   if (!old_word[fb[i]] &&  wr_word[fb[i]]) wr_word[fb[i]] = 1'b0;
                    FLT_TF_DOWN: if ( old_word[fb[i]] && !wr_word[fb[i]]) wr_word[fb[i]] = 1'b1;
                    default:     ;
                endcase
            end
        end
    end

    // Next array state: the addressed word takes wr_word, and every coupling
    // entry whose aggressor is being written flips its victim bit in the same
    // edge. A self-coupled entry (victim == aggressor) is meaningless and ignored.
    always_comb begin
        for (int w = 0; w < DEPTH; w++) begin
            mem_next[w] = mem[w];
        end
        if (wr_fire) begin
            mem_next[mem_addr] = wr_word;
            for (int i = 0; i < NUM_FAULTS; i++) begin
                if (f_valid[i] && ft[i] == FLT_CF_INV &&
                    fg[i] == mem_addr && fa[i] != fg[i]) begin
                    mem_next[fa[i]][fb[i]] = ~mem_next[fa[i]][fb[i]];
                end
            end
        end
    end

    // Stuck-at faults are also forced on readout so that a fault programmed
    // after the data was written is still visible.
    always_comb begin
        rd_word = mem[mem_addr];
        for (int i = 0; i < NUM_FAULTS; i++) begin
            if (f_valid[i] && fa[i] == mem_addr) begin
                case (ft[i])
                    FLT_SA0: rd_word[fb[i]] = 1'b0;
                    FLT_SA1: rd_word[fb[i]] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= mem_next[w];
            end
        end
    end

    // ---------------- read port and counters ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata <= '0;
            rd_valid  <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                mem_rdata <= rd_word;
            end
            if (wr_fire && wr_count != 32'hFFFF_FFFF) begin
                wr_count <= wr_count + 32'd1;
            end
            if (rd_fire && rd_count != 32'hFFFF_FFFF) begin
                rd_count <= rd_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bist_fault_memory.sv
// Directed bench for bist_fault_memory. A small March C driver stands in for
// the BIST controller; every other scenario uses hand-computed vectors.
module tb_bist_fault_memory;
    import bist_fault_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NF = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_enable = 1'b0;
    logic          mem_write = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_wdata = '0;
    logic [DW-1:0] mem_rdata;
    logic          rd_valid;
    logic          cfg_we = 1'b0;
    logic          cfg_clear = 1'b0;
    logic [1:0]    cfg_idx = '0;
    logic [2:0]    cfg_type = '0;
    logic [AW-1:0] cfg_addr = '0;
    logic [4:0]    cfg_bit = '0;
    logic [AW-1:0] cfg_aggr = '0;
    logic [31:0]   wr_count;
    logic [31:0]   rd_count;

    int n_checks = 0;
    int n_pass   = 0;

    bist_fault_memory #(
        .MEM_ADDR_WIDTH (AW),
        .MEM_DATA_WIDTH (DW),
        .NUM_FAULTS     (NF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_enable (mem_enable),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rd_valid   (rd_valid),
        .cfg_we     (cfg_we),
        .cfg_clear  (cfg_clear),
        .cfg_idx    (cfg_idx),
        .cfg_type   (cfg_type),
        .cfg_addr   (cfg_addr),
        .cfg_bit    (cfg_bit),
        .cfg_aggr   (cfg_aggr),
        .wr_count   (wr_count),
        .rd_count   (rd_count)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        mem_enable = 1'b0;
        mem_write  = 1'b0;
        cfg_we     = 1'b0;
        cfg_clear  = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        mem_enable = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = a;
        mem_wdata  = d;
        @(posedge clk);
        #1;
        mem_enable = 1'b0;
        mem_write  = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output logic v);
        @(negedge clk);
        mem_enable = 1'b1;
        mem_write  = 1'b0;
        mem_addr   = a;
        @(posedge clk);
        #1;
        d = mem_rdata;
        v = rd_valid;
        mem_enable = 1'b0;
    endtask

    task automatic set_fault(input logic [1:0] idx, input logic [2:0] ty,
                             input logic [AW-1:0] a, input logic [4:0] b,
                             input logic [AW-1:0] g);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = idx;
        cfg_type = ty;
        cfg_addr = a;
        cfg_bit  = b;
        cfg_aggr = g;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    // One March element: optional read-compare then optional write per address.
    task automatic march_elem(input bit up, input bit do_rd, input logic [DW-1:0] rexp,
                              input bit do_wr, input logic [DW-1:0] wval,
                              inout int errs, inout int err_addr);
        logic [DW-1:0] d;
        logic          v;
        for (int k = 0; k < DEPTH; k++) begin
            logic [AW-1:0] a;
            a = up ? AW'(k) : AW'(DEPTH - 1 - k);
            if (do_rd) begin
                do_read(a, d, v);
                if (d !== rexp || v !== 1'b1) begin
                    errs++;
                    err_addr = int'(a);
                end
            end
            if (do_wr) do_write(a, wval);
        end
    endtask

    task automatic run_march_c(output int errs, output int err_addr);
        errs = 0;
        err_addr = -1;
        march_elem(1'b1, 1'b0, '0, 1'b1, '0, errs, err_addr);
        march_elem(1'b1, 1'b1, '0, 1'b1, '1, errs, err_addr);
        march_elem(1'b1, 1'b1, '1, 1'b1, '0, errs, err_addr);
        march_elem(1'b0, 1'b1, '0, 1'b1, '1, errs, err_addr);
        march_elem(1'b0, 1'b1, '1, 1'b1, '0, errs, err_addr);
        march_elem(1'b1, 1'b1, '0, 1'b0, '0, errs, err_addr);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (mem_rdata !== 32'h0) $display("FAIL reset_rdata: got %h need %h", mem_rdata, 32'h0);
        else n_pass++;
        n_checks++;
        if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b need 0", rd_valid);
        else n_pass++;
        n_checks++;
        if (wr_count !== 32'd0 || rd_count !== 32'd0)
            $display("FAIL reset_counters: got wr=%0d rd=%0d need 0/0", wr_count, rd_count);
        else n_pass++;
    endtask

    task automatic test_march_clean();
        int errs, ea;
        apply_reset();
        run_march_c(errs, ea);
        n_checks++;
        if (errs !== 0) $display("FAIL march_clean_errors: got %0d need 0", errs);
        else n_pass++;
        n_checks++;
        if (wr_count !== 32'd160) $display("FAIL march_clean_wr_count: got %0d need 160", wr_count);
        else n_pass++;
        n_checks++;
        if (rd_count !== 32'd160) $display("FAIL march_clean_rd_count: got %0d need 160", rd_count);
        else n_pass++;
    endtask

    task automatic test_march_sa1();
        int errs, ea;
        apply_reset();
        set_fault(2'd0, FLT_SA1, 5'd5, 5'd3, 5'd0);
        run_march_c(errs, ea);
        n_checks++;
        if (errs !== 3) $display("FAIL march_sa1_errors: got %0d need 3", errs);
        else n_pass++;
        n_checks++;
        if (ea !== 5) $display("FAIL march_sa1_addr: got %0d need 5", ea);
        else n_pass++;
    endtask

    task automatic test_march_tf_up();
        int errs, ea;
        apply_reset();
        set_fault(2'd1, FLT_TF_UP, 5'd2, 5'd0, 5'd0);
        run_march_c(errs, ea);
        n_checks++;
        if (errs !== 2) $display("FAIL march_tf_up_errors: got %0d need 2", errs);
        else n_pass++;
        n_checks++;
        if (ea !== 2) $display("FAIL march_tf_up_addr: got %0d need 2", ea);
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [DW-1:0] d;
        logic v;
        apply_reset();
        do_write(5'd7, 32'hA5A5_A5A5);
        do_read(5'd7, d, v);
        n_checks++;
        if (d !== 32'hA5A5_A5A5 || v !== 1'b1)
            $display("FAIL write_read_7: got %h/%b need a5a5a5a5/1", d, v);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (rd_valid !== 1'b0 || mem_rdata !== 32'hA5A5_A5A5)
            $display("FAIL rd_valid_pulse_hold: got %b/%h need 0/a5a5a5a5", rd_valid, mem_rdata);
        else n_pass++;
    endtask

    task automatic test_cf_inv();
        logic [DW-1:0] d;
        logic v;
        apply_reset();
        set_fault(2'd0, FLT_CF_INV, 5'd20, 5'd31, 5'd10);
        set_fault(2'd1, FLT_CF_INV, 5'd15, 5'd0, 5'd15);
        do_write(5'd20, 32'h0);
        do_write(5'd10, 32'hFFFF_FFFF);
        do_read(5'd20, d, v);
        n_checks++;
        if (d !== 32'h8000_0000) $display("FAIL cf_inv_victim: got %h need 80000000", d);
        else n_pass++;
        do_read(5'd10, d, v);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) $display("FAIL cf_inv_aggressor: got %h need ffffffff", d);
        else n_pass++;
        do_write(5'd15, 32'h0000_0005);
        do_read(5'd15, d, v);
        n_checks++;
        if (d !== 32'h0000_0005) $display("FAIL cf_inv_self_ignored: got %h need 00000005", d);
        else n_pass++;
    endtask

    task automatic test_tf_down();
        logic [DW-1:0] d;
        logic v;
        apply_reset();
        do_write(5'd12, 32'hFFFF_FFFF);
        set_fault(2'd3, FLT_TF_DOWN, 5'd12, 5'd7, 5'd0);
        do_write(5'd12, 32'h0);
        do_read(5'd12, d, v);
        n_checks++;
        if (d !== 32'h0000_0080) $display("FAIL tf_down: got %h need 00000080", d);
        else n_pass++;
    endtask

    task automatic test_cfg_timing();
        logic [DW-1:0] d;
        logic v;
        apply_reset();
        do_write(5'd9, 32'h0);
        // Stuck-at programmed after the data was written still shows on read.
        set_fault(2'd0, FLT_SA1, 5'd9, 5'd4, 5'd0);
        do_read(5'd9, d, v);
        n_checks++;
        if (d !== 32'h0000_0010) $display("FAIL sa1_read_path: got %h need 00000010", d);
        else n_pass++;
        // Config and read in the same cycle: read sees the old table.
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_type = FLT_SA0; cfg_addr = 5'd9; cfg_bit = 5'd4;
        mem_enable = 1'b1; mem_write = 1'b0; mem_addr = 5'd9;
        @(posedge clk);
        #1;
        d = mem_rdata;
        cfg_we = 1'b0; mem_enable = 1'b0;
        n_checks++;
        if (d !== 32'h0000_0010) $display("FAIL cfg_same_cycle_old: got %h need 00000010", d);
        else n_pass++;
        // Next cycle: SA0 at higher index overrides SA1 on the same bit.
        do_read(5'd9, d, v);
        n_checks++;
        if (d !== 32'h0) $display("FAIL priority_high_idx: got %h need 00000000", d);
        else n_pass++;
        // Clear and write together: clear wins, so no SA1 on bit 0.
        @(negedge clk);
        cfg_clear = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd2; cfg_type = FLT_SA1; cfg_addr = 5'd9; cfg_bit = 5'd0;
        @(posedge clk);
        #1;
        cfg_clear = 1'b0; cfg_we = 1'b0;
        do_read(5'd9, d, v);
        n_checks++;
        if (d !== 32'h0) $display("FAIL clear_wins: got %h need 00000000", d);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] d1, d2;
        logic v1, v2;
        apply_reset();
        do_write(5'd1, 32'h1111_1111);
        do_write(5'd2, 32'h2222_2222);
        do_read(5'd1, d1, v1);
        do_read(5'd2, d2, v2);
        n_checks++;
        if (d1 !== 32'h1111_1111 || d2 !== 32'h2222_2222 || v1 !== 1'b1 || v2 !== 1'b1)
            $display("FAIL back_to_back: got %h/%h need 11111111/22222222", d1, d2);
        else n_pass++;
        do_write(5'd31, 32'hDEAD_BEEF);
        do_read(5'd31, d1, v1);
        n_checks++;
        if (d1 !== 32'hDEAD_BEEF) $display("FAIL top_addr: got %h need deadbeef", d1);
        else n_pass++;
        n_checks++;
        if (wr_count !== 32'd3 || rd_count !== 32'd3)
            $display("FAIL counters_b2b: got wr=%0d rd=%0d need 3/3", wr_count, rd_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] d;
        logic v;
        apply_reset();
        set_fault(2'd0, FLT_SA1, 5'd3, 5'd0, 5'd0);
        do_write(5'd3, 32'hFFFF_FFFF);
        @(negedge clk);
        mem_enable = 1'b1; mem_write = 1'b1; mem_addr = 5'd3; mem_wdata = 32'h1234_5678;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        mem_enable = 1'b0; mem_write = 1'b0;
        rst = 1'b0;
        n_checks++;
        if (wr_count !== 32'd0 || rd_count !== 32'd0 || rd_valid !== 1'b0 || mem_rdata !== 32'h0)
            $display("FAIL mid_reset_state: got wr=%0d rd=%0d v=%b data=%h need 0/0/0/0",
                     wr_count, rd_count, rd_valid, mem_rdata);
        else n_pass++;
        do_read(5'd3, d, v);
        n_checks++;
        if (d !== 32'h0) $display("FAIL mid_reset_read3: got %h need 00000000", d);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_march_clean();
        test_march_sa1();
        test_march_tf_up();
        test_write_read();
        test_cf_inv();
        test_tf_down();
        test_cfg_timing();
        test_back_to_back();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
